// File: rtl/booth_r4_pkg.sv
// Shared types and the radix-4 Booth digit encoder function for the sequential
// Booth multiplier.
package booth_r4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } booth_state_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_dig_t;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}; the digit is -2*t[2] + t[1] + t[0].
  function automatic booth_dig_t booth_encode(input logic [2:0] trip);
    booth_dig_t dig;
    dig.neg = trip[2];
    dig.one = trip[1] ^ trip[0];
    dig.two = (trip == 3'b100) || (trip == 3'b011);
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Combinational radix-4 Booth encoder: one multiplier triplet to a
// {neg, one, two} digit.
module booth_r4_enc
  import booth_r4_pkg::*;
(
  input  logic [2:0] i_trip,
  output booth_dig_t o_dig
);

  assign o_dig = booth_encode(i_trip);

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier, one digit per cycle, with optional
// truncation of the low product columns of every partial product.
module booth_r4_seq_mult
  import booth_r4_pkg::*;
#(
  parameter int N           = 8,
  parameter int APPROX_COLS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [N-1:0]   a,
  input  logic signed [N-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*N-1:0] p
);

  localparam int                  CNT_W      = (N / 2 > 1) ? $clog2(N / 2) : 1;
  localparam logic [CNT_W-1:0]    LAST_DIG   = CNT_W'(N / 2 - 1);
  localparam logic [2*N-1:0]      TRUNC_MASK = {(2 * N){1'b1}} << APPROX_COLS;

  // Clearing the low columns floors the partial product, also for negative values.
  function automatic logic signed [2*N-1:0] trunc_pp(input logic signed [2*N-1:0] pp);
    return pp & TRUNC_MASK;
  endfunction

  booth_state_t           r_state;
  booth_state_t           w_state_nxt;
  logic signed [2*N-1:0]  r_mcand;
  logic [N:0]             r_bext;
  logic signed [2*N-1:0]  r_acc;
  logic signed [2*N-1:0]  r_p;
  logic [CNT_W-1:0]       r_i;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_consume;
  booth_dig_t             w_dig;
  logic signed [2*N-1:0]  w_pp_mag;
  logic signed [2*N-1:0]  w_pp;
  logic signed [2*N-1:0]  w_acc_nxt;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_last    = (r_state == RUN) && (r_i == LAST_DIG);
  assign w_consume = out_ready && (r_state == DONE);

  booth_r4_enc u_enc (
    .i_trip (r_bext[2:0]),
    .o_dig  (w_dig)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (w_consume) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  assign p = r_p;

  // r_mcand already carries the 2i shift, so the selected multiple needs no extra shifter.
  always_comb begin
    w_pp_mag = '0;
    if (w_dig.one)      w_pp_mag = r_mcand;
    else if (w_dig.two) w_pp_mag = r_mcand <<< 1;
    w_pp      = w_dig.neg ? -w_pp_mag : w_pp_mag;
    w_acc_nxt = r_acc + trunc_pp(w_pp);
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mcand <= {{N{a[N-1]}}, a};
      r_bext  <= {b, 1'b0};
    end else if (r_state == RUN) begin
      r_mcand <= r_mcand <<< 2;
      r_bext  <= r_bext >> 2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_i   <= '0;
      r_p   <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_i   <= '0;
    end else if (r_state == RUN) begin
      r_acc <= w_acc_nxt;
      r_i   <= r_i + CNT_W'(1);
      if (w_last) r_p <= w_acc_nxt;
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Scoreboard bench for booth_r4_seq_mult: exact (K=0) and truncated (K=2, K=4)
// instances driven with directed vectors and a strided operand sweep.
module tb_booth_r4_seq_mult;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [7:0]   a = '0;
  logic signed [7:0]   b = '0;
  logic [2:0]          vin = '0;
  logic [2:0]          ordy = '0;
  logic [2:0]          irdy;
  logic [2:0]          ovld;
  logic signed [15:0]  pq [3];

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];
  int q2[$];

  always #5 clk = ~clk;

  booth_r4_seq_mult #(.N(8), .APPROX_COLS(0)) u_k0 (
    .clk(clk), .rst(rst), .in_valid(vin[0]), .in_ready(irdy[0]), .a(a), .b(b),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .p(pq[0]));
  booth_r4_seq_mult #(.N(8), .APPROX_COLS(2)) u_k2 (
    .clk(clk), .rst(rst), .in_valid(vin[1]), .in_ready(irdy[1]), .a(a), .b(b),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .p(pq[1]));
  booth_r4_seq_mult #(.N(8), .APPROX_COLS(4)) u_k4 (
    .clk(clk), .rst(rst), .in_valid(vin[2]), .in_ready(irdy[2]), .a(a), .b(b),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .p(pq[2]));

  task chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && ovld[0] && ordy[0]) begin
      if (q0.size() == 0) chk("unexpected_k0", int'(pq[0]), 99999);
      else chk("p_k0", int'(pq[0]), q0.pop_front());
    end
    if (!rst && ovld[1] && ordy[1]) begin
      if (q1.size() == 0) chk("unexpected_k2", int'(pq[1]), 99999);
      else chk("p_k2", int'(pq[1]), q1.pop_front());
    end
    if (!rst && ovld[2] && ordy[2]) begin
      if (q2.size() == 0) chk("unexpected_k4", int'(pq[2]), 99999);
      else chk("p_k4", int'(pq[2]), q2.pop_front());
    end
  end

  task issue(input int k, input int av, input int bv, input int exp, input bit push);
    int n;
    n = 0;
    while (!irdy[k] && n < 50) begin
      tick();
      n++;
    end
    if (!irdy[k]) chk("in_ready_timeout", 0, 1);
    a = 8'(av);
    b = 8'(bv);
    if (push) begin
      case (k)
        0: q0.push_back(exp);
        1: q1.push_back(exp);
        default: q2.push_back(exp);
      endcase
    end
    vin[k] = 1'b1;
    tick();
    vin[k] = 1'b0;
  endtask

  initial begin
    int corner [10];
    int n;
    corner = '{-128, -127, -86, -2, -1, 0, 1, 2, 85, 127};

    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", int'(irdy[k]), 1);
      chk("rst_out_valid", int'(ovld[k]), 0);
      chk("rst_p", int'(pq[k]), 0);
    end

    // Latency: out_valid rises exactly 4 edges after the accept edge.
    ordy = 3'b111;
    issue(0, -128, -128, 16384, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("lat_out_valid", int'(ovld[0]), (e == 4) ? 1 : 0);
      chk("lat_in_ready", int'(irdy[0]), 0);
    end
    tick();
    chk("consume_in_ready", int'(irdy[0]), 1);
    chk("consume_out_valid", int'(ovld[0]), 0);

    // Truncated instances.
    issue(2, 3, 5, 0, 1'b1);
    issue(2, -128, -128, 16384, 1'b1);
    issue(1, -1, 1, -4, 1'b1);
    issue(1, 3, 5, 12, 1'b1);

    // Backpressure: result held in DONE while out_ready is low.
    ordy[0] = 1'b0;
    issue(0, 7, -3, -21, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("bp_run_in_ready", int'(irdy[0]), 0);
    end
    chk("bp_done_valid", int'(ovld[0]), 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid", int'(ovld[0]), 1);
      chk("bp_hold_p", int'(pq[0]), -21);
      chk("bp_hold_in_ready", int'(irdy[0]), 0);
    end
    ordy[0] = 1'b1;
    tick();
    chk("bp_release_in_ready", int'(irdy[0]), 1);
    chk("bp_release_valid", int'(ovld[0]), 0);

    // Reset during the second RUN cycle discards the partial result.
    issue(0, 100, 100, 0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", int'(irdy[0]), 1);
    chk("midrst_out_valid", int'(ovld[0]), 0);
    chk("midrst_p", int'(pq[0]), 0);
    issue(0, 2, 3, 6, 1'b1);

    // Corner cross product and strided sweep on the exact instance.
    foreach (corner[i])
      foreach (corner[j])
        issue(0, corner[i], corner[j], corner[i] * corner[j], 1'b1);
    for (int av = -128; av < 128; av += 7)
      for (int bv = -128; bv < 128; bv += 11)
        issue(0, av, bv, av * bv, 1'b1);

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
